serial_addsub: RTL

Parametrised, multi-cycle integer add/subtract unit that processes its operands CHUNK bits per clock with a registered carry chain. It replaces the fixed 32-bit ripple adder/subtractor in the datapath wherever the full-width ripple path would limit the clock period. Operands enter through a valid/ready handshake and results leave through one. The result carries MIPS-style status flags: carry, signed overflow and zero.

---
 rtl/addsub_pkg.sv | 16 +
 rtl/addsub_chunk.sv | 31 +++
 rtl/serial_addsub.sv | 129 ++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..n-1, never less than one so a single-chunk
  // build still has a legal counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the caller can derive signed overflow.
module addsub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // NOTE: blocking assignments inside always_comb; every output gets a value
  // on every pass so no latch is inferred.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock through a single
// ripple adder with a registered carry, result and MIPS-style flags on a handshake.
module serial_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  import addsub_pkg::*;

  if (CHUNK < 1 || (WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0) begin : g_bad_params
    $fatal(1, "serial_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  localparam int unsigned NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CW     = cnt_width(NCHUNK);
  localparam int unsigned IW     = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_next;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;

  logic [IW-1:0]    base;
  logic [CHUNK-1:0] x;
  logic [CHUNK-1:0] y;
  logic [CHUNK-1:0] s;
  logic             cout;
  logic             c_msb;
  logic             accept;

  assign accept = in_valid && (state == IDLE);
  assign base   = IW'(cnt * CHUNK);
  assign x      = a_q[base +: CHUNK];
  assign y      = b_q[base +: CHUNK];

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x     (x),
    .y     (y),
    .cin   (carry_q),
    .s     (s),
    .cout  (cout),
    .c_msb (c_msb)
  );

  always_comb begin
    sum_next              = sum_q;
    sum_next[base +: CHUNK] = s;
  end

  // NOTE: operand registers carry no reset; they are always loaded on accept
  // before being read, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b ^ {WIDTH{sub}};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state   <= RUN;
            cnt     <= '0;
            carry_q <= carry_in ^ sub;
          end
        end
        RUN: begin
          sum_q   <= sum_next;
          carry_q <= cout;
          if (cnt == LAST) begin
            // Flags are taken from the final slice while its carries are live.
            state       <= DONE;
            cnt         <= '0;
            carry_out_q <= cout;
            overflow_q  <= c_msb ^ cout;
            zero_q      <= (sum_next == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
